// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped read-only instruction cache with single-line refill FSM
module icache_fetch #(
  parameter int INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         rollback,
  input  logic         fetch_en,
  input  logic [31:0]  fetch_pc,
  output logic         fetch_hit,
  output logic [31:0]  fetch_inst,
  output logic         mc_en,
  output logic [31:0]  mc_pc,
  input  logic         mc_done,
  input  logic [511:0] mc_data
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TW = 26 - INDEX_BITS;
  typedef enum logic {IDLE, REFILL} state_t;
  state_t state;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [511:0] lines [LINES];
  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TW-1:0] tag;
  logic present, fill, pc_unused;
  assign idx = fetch_pc[5+INDEX_BITS:6];
  assign tag = fetch_pc[31:6+INDEX_BITS];
  assign fill_idx = mc_pc[5+INDEX_BITS:6];
  assign pc_unused = ^fetch_pc[1:0];
  assign present = valid[idx] && tags[idx] == tag;
  assign fetch_hit = rst && rdy && fetch_en && !rollback && present;
  assign fetch_inst = fetch_hit ? lines[idx][{fetch_pc[5:2], 5'b0} +: 32] : '0;
  assign fill = state == REFILL && rdy && mc_done;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mc_en <= 1'b0;
      mc_pc <= '0;
      valid <= '0;
    end else if (rdy) begin
      if (state == IDLE && fetch_en && !rollback && !present) begin
        state <= REFILL;
        mc_en <= 1'b1;
        mc_pc <= {fetch_pc[31:6], 6'b0};
      end else if (fill) begin
        state <= IDLE;
        mc_en <= 1'b0;
        valid[fill_idx] <= 1'b1;
      end
    end
  end
  // Tag and data arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[fill_idx] <= mc_pc[31:6+INDEX_BITS];
      lines[fill_idx] <= mc_data;
    end
  end
endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: directed self-checking bench for icache_fetch
module tb_icache_fetch;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, rollback = 1'b0, fetch_en = 1'b0, mc_done = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic [511:0] mc_data = '0;
  logic fetch_hit, mc_en;
  logic [31:0] fetch_inst, mc_pc;
  int compared = 0, mismatched = 0;
  icache_fetch #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .fetch_en(fetch_en),
    .fetch_pc(fetch_pc), .fetch_hit(fetch_hit), .fetch_inst(fetch_inst),
    .mc_en(mc_en), .mc_pc(mc_pc), .mc_done(mc_done), .mc_data(mc_data)
  );
  always #5 clk = ~clk;
  function automatic logic [511:0] mk(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction
  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [511:0] line_a, line_b, line_c;
  initial begin
    line_a = mk(32'h1000_0000);
    line_a[127:96] = 32'h00A0_0093;
    line_b = mk(32'h1400_0000);
    line_c = mk(32'h2000_0000);
    #2;
    chk("rst_hit", 32'(fetch_hit), 0);
    chk("rst_inst", fetch_inst, 0);
    chk("rst_mc_en", 32'(mc_en), 0);
    chk("rst_mc_pc", mc_pc, 0);
    #10 rst = 1'b1;
    tick();
    // cold miss
    fetch_en = 1'b1; fetch_pc = 32'h1000; #1;
    chk("cold_hit0", 32'(fetch_hit), 0);
    tick();
    chk("cold_mc_en", 32'(mc_en), 1);
    chk("cold_mc_pc", mc_pc, 32'h1000);
    tick();
    mc_done = 1'b1; mc_data = line_a; #1;
    chk("cold_inflight", 32'(fetch_hit), 0);
    tick();
    mc_done = 1'b0;
    chk("cold_mc_en_drop", 32'(mc_en), 0);
    fetch_pc = 32'h100C; #1;
    chk("cold_hit", 32'(fetch_hit), 1);
    chk("cold_inst", fetch_inst, 32'h00A0_0093);
    // hits within line
    fetch_pc = 32'h1000; #1;
    chk("w0_inst", fetch_inst, 32'h1000_0000);
    fetch_pc = 32'h103C; #1;
    chk("w15_hit", 32'(fetch_hit), 1);
    chk("w15_inst", fetch_inst, 32'h1000_000F);
    tick();
    chk("hit_no_req", 32'(mc_en), 0);
    // conflict eviction
    fetch_pc = 32'h1400; #1;
    chk("evict_miss", 32'(fetch_hit), 0);
    tick();
    chk("evict_mc_en", 32'(mc_en), 1);
    chk("evict_mc_pc", mc_pc, 32'h1400);
    mc_done = 1'b1; mc_data = line_b;
    tick();
    mc_done = 1'b0;
    chk("evict_done", 32'(mc_en), 0);
    fetch_pc = 32'h1404; #1;
    chk("evict_inst", fetch_inst, 32'h1400_0001);
    fetch_pc = 32'h1000; #1;
    chk("old_miss", 32'(fetch_hit), 0);
    tick();
    chk("old_mc_pc", mc_pc, 32'h1000);
    // rollback during refill
    fetch_pc = 32'h1400; #1;
    chk("refill_hit_served", 32'(fetch_hit), 1);
    rollback = 1'b1; #1;
    chk("rb_masks_hit", 32'(fetch_hit), 0);
    tick();
    rollback = 1'b0;
    chk("rb_mc_en", 32'(mc_en), 1);
    chk("rb_mc_pc", mc_pc, 32'h1000);
    fetch_pc = 32'h2000;
    tick();
    chk("rb_busy_mc_pc", mc_pc, 32'h1000);
    mc_done = 1'b1; mc_data = line_a;
    tick();
    mc_done = 1'b0;
    chk("rb_done", 32'(mc_en), 0);
    fetch_pc = 32'h1000; #1;
    chk("rb_installed", fetch_inst, 32'h1000_0000);
    fetch_pc = 32'h2000; #1;
    chk("new_pc_miss", 32'(fetch_hit), 0);
    tick();
    chk("new_mc_en", 32'(mc_en), 1);
    chk("new_mc_pc", mc_pc, 32'h2000);
    // async reset mid-refill
    rst = 1'b0; #1;
    chk("arst_mc_en", 32'(mc_en), 0);
    chk("arst_mc_pc", mc_pc, 0);
    fetch_en = 1'b0; #1 rst = 1'b1;
    tick();
    mc_done = 1'b1; mc_data = line_c;
    tick();
    mc_done = 1'b0;
    chk("stray_done", 32'(mc_en), 0);
    fetch_en = 1'b1; fetch_pc = 32'h1000; #1;
    chk("arst_invalid", 32'(fetch_hit), 0);
    tick();
    chk("arst_refill_pc", mc_pc, 32'h1000);
    mc_done = 1'b1; mc_data = line_a;
    tick();
    mc_done = 1'b0;
    // rdy low in refill
    fetch_pc = 32'h1040; #1;
    chk("idx1_miss", 32'(fetch_hit), 0);
    tick();
    chk("idx1_mc_pc", mc_pc, 32'h1040);
    fetch_pc = 32'h1000; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mc_done = (i == 1); mc_data = line_b; #1;
      chk("rdy0_hit", 32'(fetch_hit), 0);
      chk("rdy0_mc_en", 32'(mc_en), 1);
      chk("rdy0_mc_pc", mc_pc, 32'h1040);
      tick();
    end
    mc_done = 1'b0; rdy = 1'b1; #1;
    chk("rdy1_hit", 32'(fetch_hit), 1);
    chk("rdy1_inst", fetch_inst, 32'h1000_0000);
    chk("rdy1_mc_en", 32'(mc_en), 1);
    mc_done = 1'b1; mc_data = line_c;
    tick();
    mc_done = 1'b0;
    chk("rdy1_done", 32'(mc_en), 0);
    fetch_pc = 32'h1048; #1;
    chk("idx1_inst", fetch_inst, 32'h2000_0002);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
